// File: rtl/irq_pending_latch_pkg.sv
// Shared types and defaults for the interrupt pending latch.
package irq_pkg;

  localparam int N_LINES_DEF = 4;
  localparam int CNT_W_DEF   = 2;

  typedef logic [CNT_W_DEF-1:0]           irq_cnt_t;
  typedef logic [$clog2(N_LINES_DEF)-1:0] irq_idx_t;

  // Per-line counter action resolved from clr/inc/dec and the current count.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_INC,
    ACT_SAT,
    ACT_DEC,
    ACT_UNDER
  } cnt_act_e;

endpackage

// File: rtl/irq_pending_latch_if.sv
// Consumer-side bundle: ack handshake in, pending vector and ack error out.
interface irq_pending_latch_if
  import irq_pkg::*;
#(
  parameter int N_LINES = N_LINES_DEF
);

  localparam int IDX_W = $clog2(N_LINES);

  logic               ack_valid;
  logic [IDX_W-1:0]   ack_idx;
  logic               ack_err;
  logic [N_LINES-1:0] pending;
  logic               any_pend;

  modport master (
    output ack_valid,
    output ack_idx,
    input  ack_err,
    input  pending,
    input  any_pend
  );

  modport slave (
    input  ack_valid,
    input  ack_idx,
    output ack_err,
    output pending,
    output any_pend
  );

endinterface

// File: rtl/irq_pending_latch_line_counter.sv
// Saturating up/down counter for one interrupt line with sticky overflow.
module irq_line_counter
  import irq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cnt_act_e act;

  always_comb begin
    act = ACT_HOLD;
    if (clr)              act = ACT_CLR;
    else if (inc && dec)  act = ACT_HOLD;
    else if (inc)         act = (cnt == CNT_MAX) ? ACT_SAT : ACT_INC;
    else if (dec)         act = (cnt == '0) ? ACT_UNDER : ACT_DEC;
  end

  assign underflow = (act == ACT_UNDER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      case (act)
        ACT_CLR: begin
          cnt      <= '0;
          overflow <= 1'b0;
        end
        ACT_INC: cnt      <= cnt + 1'b1;
        ACT_SAT: overflow <= 1'b1;
        ACT_DEC: cnt      <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/irq_pending_latch.sv
// Per-line pending counters feeding a masked pending vector to the priority encoder.
// Build option: define IRQ_EDGE_DETECT_EN to treat irq_in as level-type (rising-edge counted).
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int N_LINES = N_LINES_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_LINES-1:0]  irq_in,
  input  logic [N_LINES-1:0]  mask,
  input  logic                clr_all,
  output logic [N_LINES-1:0]  overflow,
  irq_pending_latch_if.slave  cons
);

  localparam int IDX_W = $clog2(N_LINES);
  localparam logic [IDX_W:0] N_LINES_EXT = (IDX_W+1)'(N_LINES);

  logic [N_LINES-1:0] req;
  logic [N_LINES-1:0] ack_hit;
  logic [N_LINES-1:0] underflow;
  logic [N_LINES-1:0] cnt_nz;
  logic [IDX_W:0]     idx_ext;
  logic               idx_bad;
  logic [N_LINES-1:0] pending_d;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_LINES-1:0] irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= '0;
    else        irq_q <= irq_in;
  end

  assign req = irq_in & ~irq_q;
`else
  assign req = irq_in;
`endif

  // Index is zero-extended so out-of-range acks are detectable for any N_LINES.
  assign idx_ext = {1'b0, cons.ack_idx};
  assign idx_bad = cons.ack_valid && (idx_ext >= N_LINES_EXT);

  always_comb begin
    ack_hit = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      ack_hit[i] = cons.ack_valid && (idx_ext == (IDX_W+1)'(i));
    end
  end

  for (genvar g = 0; g < N_LINES; g++) begin : g_line
    logic [CNT_W-1:0] cnt;

    irq_line_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr_all),
      .inc       (req[g]),
      .dec       (ack_hit[g]),
      .cnt       (cnt),
      .overflow  (overflow[g]),
      .underflow (underflow[g])
    );

    assign cnt_nz[g] = (cnt != '0);
  end

  assign pending_d = cnt_nz & mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cons.pending  <= '0;
      cons.any_pend <= 1'b0;
      cons.ack_err  <= 1'b0;
    end else begin
      cons.pending  <= pending_d;
      cons.any_pend <= |pending_d;
      cons.ack_err  <= (|underflow) || (idx_bad && !clr_all);
    end
  end

endmodule
